// File: rtl/frame_parser_mon_pkg.sv
// Shared definitions for the Frame_Parser CRC-error monitor.
//   mon_state_t    : episode FSM encoding
//   MON_V_*        : violation codes reported on first_code
//   FLAG_*         : bit positions inside sticky_flags
package frame_parser_mon_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } mon_state_t;

  localparam logic [1:0] MON_V_NONE     = 2'd0;
  localparam logic [1:0] MON_V_DEADLINE = 2'd1;
  localparam logic [1:0] MON_V_VALID    = 2'd2;
  localparam logic [1:0] MON_V_OK       = 2'd3;

  localparam int unsigned FLAG_DEADLINE = 0;
  localparam int unsigned FLAG_VALID    = 1;
  localparam int unsigned FLAG_OK       = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : synchronous active-high reset
//   clr   : zero the count; an inc in the same cycle is applied afterwards
//   inc   : add one unless already at all-ones
//   count : current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) count_d = '0;
    if (inc && (count_d != '1)) count_d = count_d + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/frame_parser_crc_monitor.sv
// Passive runtime monitor for Frame_Parser CRC-error reporting. Each CRC
// mismatch seen in VALIDATE starts an episode that checks:
//   DEADLINE       : STATUS_CRC_ERR within DEADLINE cycles of the trigger
//   SPURIOUS_VALID : no frame_valid while the mismatch is pending
//   OK_RETURN      : no STATUS_OK once the error has been reported
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   enable                : monitor enable (low aborts any episode)
//   clear                 : zero flags, counters and first capture
//   state, frame_valid, frame_consumed, received_crc, expected_crc,
//   error_status_reg      : tapped parser signals
//   sticky_flags          : [0] DEADLINE, [1] SPURIOUS_VALID, [2] OK_RETURN
//   violation_pulse       : registered pulse one cycle after a new violation
//   mismatch_count        : episodes started (saturating)
//   violation_count       : cycles with a new violation (saturating)
//   first_code            : code of the first violation, 0 if none
//   first_timestamp       : free-running cycle count at the first violation
module frame_parser_crc_monitor
  import frame_parser_mon_pkg::*;
#(
  parameter int unsigned           STATE_W        = 4,
  parameter int unsigned           CRC_W          = 8,
  parameter int unsigned           STATUS_W       = 8,
  parameter logic [STATE_W-1:0]    VALIDATE_CODE  = 4'h8,
  parameter logic [STATE_W-1:0]    ERROR_CODE     = 4'h9,
  parameter logic [STATUS_W-1:0]   STATUS_OK      = 8'h00,
  parameter logic [STATUS_W-1:0]   STATUS_CRC_ERR = 8'h01,
  parameter int unsigned           DEADLINE       = 2,
  parameter int unsigned           CNT_W          = 16,
  parameter int unsigned           TS_W           = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic [STATE_W-1:0]  state,
  input  logic                frame_valid,
  input  logic                frame_consumed,
  input  logic [CRC_W-1:0]    received_crc,
  input  logic [CRC_W-1:0]    expected_crc,
  input  logic [STATUS_W-1:0] error_status_reg,
  output logic [2:0]          sticky_flags,
  output logic                violation_pulse,
  output logic [CNT_W-1:0]    mismatch_count,
  output logic [CNT_W-1:0]    violation_count,
  output logic [1:0]          first_code,
  output logic [TS_W-1:0]     first_timestamp
);

  localparam int unsigned       TMR_W    = ($clog2(DEADLINE + 1) > 0) ? $clog2(DEADLINE + 1) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(DEADLINE);

  mon_state_t        fsm_q, fsm_d;
  logic [TMR_W-1:0]  timer_q, timer_d, timer_cur;
  logic              win_q, win_d;
  logic              valid_done_q, valid_done_d;
  logic              ok_done_q, ok_done_d;
  logic [2:0]        flags_q, flags_d;
  logic              pulse_q;
  logic [1:0]        first_code_q, first_code_d;
  logic [TS_W-1:0]   first_ts_q, first_ts_d;
  logic [TS_W-1:0]   ts_q;

  logic in_val, mism, crc_err, status_ok, leave, trigger;
  logic v_deadline, v_valid, v_ok, new_any;

  assign in_val    = (state == VALIDATE_CODE);
  assign mism      = in_val && (received_crc != expected_crc);
  assign crc_err   = (error_status_reg == STATUS_CRC_ERR);
  assign status_ok = (error_status_reg == STATUS_OK);
  assign leave     = frame_consumed || !in_val;
  assign trigger   = enable && (fsm_q == StIdle) && mism;
  // The trigger cycle is evaluated as ARMED cycle 0.
  assign timer_cur = (fsm_q == StIdle) ? '0 : timer_q;

  always_comb begin
    fsm_d        = fsm_q;
    timer_d      = timer_q;
    win_d        = win_q;
    valid_done_d = valid_done_q;
    ok_done_d    = ok_done_q;
    v_deadline   = 1'b0;
    v_valid      = 1'b0;
    v_ok         = 1'b0;

    if (!enable) begin
      fsm_d        = StIdle;
      timer_d      = '0;
      win_d        = 1'b0;
      valid_done_d = 1'b0;
      ok_done_d    = 1'b0;
    end else begin
      // SPURIOUS_VALID window runs independently of the FSM; the closing
      // cycle is still inside the window.
      if (trigger || win_q) begin
        if (frame_valid && !valid_done_q) begin
          v_valid      = 1'b1;
          valid_done_d = 1'b1;
        end
        win_d = !leave;
      end

      unique case (fsm_q)
        StIdle, StArmed: begin
          if (trigger || (fsm_q == StArmed)) begin
            if (crc_err) begin
              fsm_d = StHold;
            end else if (timer_cur == TMR_LAST) begin
              v_deadline = 1'b1;
              fsm_d      = StDrain;
            end else begin
              fsm_d   = StArmed;
              timer_d = timer_cur + TMR_W'(1);
            end
          end
        end
        StHold: begin
          if (status_ok && !ok_done_q) begin
            v_ok      = 1'b1;
            ok_done_d = 1'b1;
          end
          if (frame_consumed || (state == ERROR_CODE)) fsm_d = StIdle;
        end
        StDrain: begin
          if (leave) fsm_d = StIdle;
        end
      endcase

      if ((fsm_d == StIdle) && (fsm_q != StIdle)) begin
        timer_d      = '0;
        win_d        = 1'b0;
        valid_done_d = 1'b0;
        ok_done_d    = 1'b0;
      end
    end
  end

  assign new_any = v_deadline || v_valid || v_ok;

  // Clear is applied first so same-cycle violations survive it.
  always_comb begin
    flags_d      = clear ? 3'b000 : flags_q;
    first_code_d = clear ? MON_V_NONE : first_code_q;
    first_ts_d   = clear ? '0 : first_ts_q;
    flags_d[FLAG_DEADLINE] = flags_d[FLAG_DEADLINE] | v_deadline;
    flags_d[FLAG_VALID]    = flags_d[FLAG_VALID] | v_valid;
    flags_d[FLAG_OK]       = flags_d[FLAG_OK] | v_ok;
    if (new_any && (first_code_d == MON_V_NONE)) begin
      first_ts_d = ts_q;
      if (v_deadline)   first_code_d = MON_V_DEADLINE;
      else if (v_valid) first_code_d = MON_V_VALID;
      else              first_code_d = MON_V_OK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= StIdle;
      timer_q      <= '0;
      win_q        <= 1'b0;
      valid_done_q <= 1'b0;
      ok_done_q    <= 1'b0;
      flags_q      <= 3'b000;
      pulse_q      <= 1'b0;
      first_code_q <= MON_V_NONE;
      first_ts_q   <= '0;
      ts_q         <= '0;
    end else begin
      fsm_q        <= fsm_d;
      timer_q      <= timer_d;
      win_q        <= win_d;
      valid_done_q <= valid_done_d;
      ok_done_q    <= ok_done_d;
      flags_q      <= flags_d;
      pulse_q      <= new_any;
      first_code_q <= first_code_d;
      first_ts_q   <= first_ts_d;
      ts_q         <= ts_q + TS_W'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (trigger),
    .count (mismatch_count)
  );

  sat_counter #(.W(CNT_W)) u_violation_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (new_any),
    .count (violation_count)
  );

  assign sticky_flags    = flags_q;
  assign violation_pulse = pulse_q;
  assign first_code      = first_code_q;
  assign first_timestamp = first_ts_q;

endmodule

// File: tb/tb_frame_parser_crc_monitor.sv
// Directed self-checking bench for frame_parser_crc_monitor. A second
// instance with a 4-bit counter width exercises counter saturation.
module tb_frame_parser_crc_monitor;

  localparam logic [3:0] ST_IDLE = 4'h0;
  localparam logic [3:0] ST_VAL  = 4'h8;
  localparam logic [3:0] ST_ERR  = 4'h9;

  logic        clk = 1'b0;
  logic        rst, enable, clear;
  logic [3:0]  state;
  logic        frame_valid, frame_consumed;
  logic [7:0]  received_crc, expected_crc, error_status_reg;

  logic [2:0]  sticky_flags;
  logic        violation_pulse;
  logic [15:0] mismatch_count, violation_count;
  logic [1:0]  first_code;
  logic [31:0] first_timestamp;

  logic [2:0]  s_flags;
  logic        s_pulse;
  logic [3:0]  s_mismatch_count, s_violation_count;
  logic [1:0]  s_first_code;
  logic [31:0] s_first_timestamp;

  logic [31:0] tb_cyc;
  logic [31:0] exp_ts;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Reference free-running cycle count.
  always @(posedge clk) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  frame_parser_crc_monitor dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .clear            (clear),
    .state            (state),
    .frame_valid      (frame_valid),
    .frame_consumed   (frame_consumed),
    .received_crc     (received_crc),
    .expected_crc     (expected_crc),
    .error_status_reg (error_status_reg),
    .sticky_flags     (sticky_flags),
    .violation_pulse  (violation_pulse),
    .mismatch_count   (mismatch_count),
    .violation_count  (violation_count),
    .first_code       (first_code),
    .first_timestamp  (first_timestamp)
  );

  frame_parser_crc_monitor #(.CNT_W(4)) dut_s (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .clear            (clear),
    .state            (state),
    .frame_valid      (frame_valid),
    .frame_consumed   (frame_consumed),
    .received_crc     (received_crc),
    .expected_crc     (expected_crc),
    .error_status_reg (error_status_reg),
    .sticky_flags     (s_flags),
    .violation_pulse  (s_pulse),
    .mismatch_count   (s_mismatch_count),
    .violation_count  (s_violation_count),
    .first_code       (s_first_code),
    .first_timestamp  (s_first_timestamp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] st, input logic fv, input logic fc,
                        input logic [7:0] rx, input logic [7:0] ex, input logic [7:0] sts);
    state            = st;
    frame_valid      = fv;
    frame_consumed   = fc;
    received_crc     = rx;
    expected_crc     = ex;
    error_status_reg = sts;
  endtask

  task automatic idle_in;
    set_in(ST_IDLE, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic mism_in(input logic fv, input logic fc, input logic [7:0] sts);
    set_in(ST_VAL, fv, fc, 8'hA5, 8'h5A, sts);
  endtask

  task automatic do_clear;
    idle_in();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    idle_in();
    tick(); tick();
    n_checks++;
    if ({sticky_flags, violation_pulse, first_code} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b/%b/%0d want 0", sticky_flags, violation_pulse, first_code);
    end
    n_checks++;
    if ({mismatch_count, violation_count, first_timestamp} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0d/%0d/%0d want 0", mismatch_count, violation_count,
               first_timestamp);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_deadline_met;
    mism_in(1'b0, 1'b0, 8'h00); tick();
    mism_in(1'b0, 1'b0, 8'h00); tick();
    mism_in(1'b0, 1'b0, 8'h01); tick();
    mism_in(1'b0, 1'b1, 8'h01); tick();
    idle_in(); tick();
    n_checks++;
    if (sticky_flags !== 3'b000) begin
      n_fail++; $display("FAIL met_flags: got %b want 000", sticky_flags);
    end
    n_checks++;
    if (mismatch_count !== 16'd1 || violation_count !== 16'd0) begin
      n_fail++;
      $display("FAIL met_counts: got %0d/%0d want 1/0", mismatch_count, violation_count);
    end
  endtask

  task automatic test_deadline_miss;
    mism_in(1'b0, 1'b0, 8'h00); tick();
    mism_in(1'b0, 1'b0, 8'h00); tick();
    n_checks++;
    if (violation_pulse !== 1'b0 || sticky_flags !== 3'b000) begin
      n_fail++;
      $display("FAIL miss_early: got pulse %b flags %b want 0/000", violation_pulse, sticky_flags);
    end
    exp_ts = tb_cyc;
    mism_in(1'b0, 1'b0, 8'h00); tick();
    n_checks++;
    if (violation_pulse !== 1'b1 || sticky_flags !== 3'b001) begin
      n_fail++;
      $display("FAIL miss_flag: got pulse %b flags %b want 1/001", violation_pulse, sticky_flags);
    end
    n_checks++;
    if (first_code !== 2'd1 || first_timestamp !== exp_ts) begin
      n_fail++;
      $display("FAIL miss_first: got %0d@%0d want 1@%0d", first_code, first_timestamp, exp_ts);
    end
    mism_in(1'b0, 1'b0, 8'h01); tick();
    n_checks++;
    if (violation_pulse !== 1'b0) begin
      n_fail++; $display("FAIL miss_pulse_width: got %b want 0", violation_pulse);
    end
    idle_in(); tick();
    n_checks++;
    if (violation_count !== 16'd1 || mismatch_count !== 16'd2) begin
      n_fail++;
      $display("FAIL miss_counts: got %0d/%0d want 1/2", violation_count, mismatch_count);
    end
  endtask

  task automatic test_spurious_valid;
    do_clear();
    mism_in(1'b0, 1'b0, 8'h01); tick();
    mism_in(1'b1, 1'b0, 8'h01); tick();
    mism_in(1'b1, 1'b0, 8'h01); tick();
    n_checks++;
    if (violation_pulse !== 1'b0 || sticky_flags !== 3'b010) begin
      n_fail++;
      $display("FAIL spur_flag: got pulse %b flags %b want 0/010", violation_pulse, sticky_flags);
    end
    mism_in(1'b1, 1'b0, 8'h01); tick();
    mism_in(1'b1, 1'b0, 8'h01); tick();
    mism_in(1'b0, 1'b1, 8'h01); tick();
    idle_in(); tick();
    n_checks++;
    if (first_code !== 2'd2 || violation_count !== 16'd1 || mismatch_count !== 16'd1) begin
      n_fail++;
      $display("FAIL spur_summary: got code %0d vc %0d mc %0d want 2/1/1", first_code,
               violation_count, mismatch_count);
    end
  endtask

  task automatic test_ok_return;
    do_clear();
    mism_in(1'b0, 1'b0, 8'h01); tick();
    mism_in(1'b0, 1'b0, 8'h00); tick();
    mism_in(1'b0, 1'b0, 8'h00); tick();
    mism_in(1'b0, 1'b1, 8'h01); tick();
    idle_in(); tick();
    n_checks++;
    if (sticky_flags !== 3'b100 || first_code !== 2'd3 || violation_count !== 16'd1) begin
      n_fail++;
      $display("FAIL ok_flag: got flags %b code %0d vc %0d want 100/3/1", sticky_flags, first_code,
               violation_count);
    end
    do_clear();
    mism_in(1'b0, 1'b0, 8'h01); tick();
    set_in(ST_ERR, 1'b0, 1'b0, 8'hA5, 8'h5A, 8'h01); tick();
    set_in(ST_ERR, 1'b0, 1'b0, 8'hA5, 8'h5A, 8'h00); tick();
    idle_in(); tick();
    n_checks++;
    if (sticky_flags !== 3'b000 || violation_count !== 16'd0) begin
      n_fail++;
      $display("FAIL ok_after_err: got flags %b vc %0d want 000/0", sticky_flags, violation_count);
    end
  endtask

  task automatic test_combined_and_clear;
    do_clear();
    mism_in(1'b0, 1'b0, 8'h00); tick();
    mism_in(1'b1, 1'b0, 8'h00); tick();
    n_checks++;
    if (first_code !== 2'd2) begin
      n_fail++; $display("FAIL comb_first: got %0d want 2", first_code);
    end
    mism_in(1'b0, 1'b0, 8'h00); tick();
    set_in(ST_IDLE, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01); tick();
    idle_in(); tick();
    n_checks++;
    if (sticky_flags !== 3'b011 || first_code !== 2'd2 || violation_count !== 16'd2) begin
      n_fail++;
      $display("FAIL comb_summary: got flags %b code %0d vc %0d want 011/2/2", sticky_flags,
               first_code, violation_count);
    end
    // Fresh DEADLINE violation in the same cycle as clear.
    mism_in(1'b0, 1'b0, 8'h00); tick();
    mism_in(1'b0, 1'b0, 8'h00); tick();
    mism_in(1'b0, 1'b0, 8'h00); clear = 1'b1; tick(); clear = 1'b0;
    n_checks++;
    if (sticky_flags !== 3'b001 || violation_count !== 16'd1 || first_code !== 2'd1 ||
        mismatch_count !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_race_viol: got flags %b vc %0d code %0d mc %0d want 001/1/1/0",
               sticky_flags, violation_count, first_code, mismatch_count);
    end
    idle_in(); tick();
    // Trigger in the same cycle as clear.
    mism_in(1'b0, 1'b0, 8'h01); clear = 1'b1; tick(); clear = 1'b0;
    n_checks++;
    if (mismatch_count !== 16'd1 || violation_count !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_race_trig: got mc %0d vc %0d want 1/0", mismatch_count,
               violation_count);
    end
    mism_in(1'b0, 1'b1, 8'h01); tick();
    idle_in(); tick();
  endtask

  task automatic test_enable;
    do_clear();
    mism_in(1'b0, 1'b0, 8'h00); tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mism_in(1'b1, 1'b0, 8'h00); tick();
    end
    n_checks++;
    if (mismatch_count !== 16'd1) begin
      n_fail++; $display("FAIL en_no_trigger: got %0d want 1", mismatch_count);
    end
    idle_in(); tick();
    enable = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (sticky_flags !== 3'b000 || violation_count !== 16'd0 || violation_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL en_abort: got flags %b vc %0d pulse %b want 000/0/0", sticky_flags,
               violation_count, violation_pulse);
    end
  endtask

  task automatic test_saturation;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      mism_in(1'b0, 1'b0, 8'h01); tick();
      mism_in(1'b0, 1'b1, 8'h01); tick();
      idle_in(); tick();
    end
    n_checks++;
    if (s_mismatch_count !== 4'hF) begin
      n_fail++; $display("FAIL sat_small: got %0h want f", s_mismatch_count);
    end
    n_checks++;
    if (mismatch_count !== 16'd20 || sticky_flags !== 3'b000) begin
      n_fail++;
      $display("FAIL sat_wide: got mc %0d flags %b want 20/000", mismatch_count, sticky_flags);
    end
  endtask

  task automatic test_reset_mid_armed;
    mism_in(1'b0, 1'b0, 8'h00); tick();
    mism_in(1'b0, 1'b0, 8'h00); tick();
    rst = 1'b1;
    mism_in(1'b0, 1'b0, 8'h00); tick();
    n_checks++;
    if ({sticky_flags, violation_pulse, first_code} !== 6'd0 ||
        {mismatch_count, violation_count, first_timestamp} !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got flags %b pulse %b mc %0d vc %0d want all 0", sticky_flags,
               violation_pulse, mismatch_count, violation_count);
    end
    idle_in();
    rst = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (sticky_flags !== 3'b000 || violation_count !== 16'd0 || violation_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_deadline: got flags %b vc %0d want 000/0", sticky_flags,
               violation_count);
    end
  endtask

  initial begin
    test_reset();
    test_deadline_met();
    test_deadline_miss();
    test_spurious_valid();
    test_ok_return();
    test_combined_and_clear();
    test_enable();
    test_saturation();
    test_reset_mid_armed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
